// File: rtl/kuznechik_pkg.sv
// rtl/kuznechik_pkg.sv - Kuznechik constants, S-box, L transform and key-expansion state type
package kuznechik_pkg;

    localparam int NUM_RKEYS = 10;
    localparam int NUM_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        EMIT
    } state_t;

    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Index 0 multiplies the most significant byte.
    localparam logic [7:0] L_COEF [16] = '{
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] r_step(input logic [127:0] x);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ gf_mul(x[8*(15-i) +: 8], L_COEF[i]);
        end
        return {acc, x[127:8]};
    endfunction

    function automatic logic [127:0] l_transform(input logic [127:0] x);
        logic [127:0] v;
        v = x;
        for (int i = 0; i < 16; i++) v = r_step(v);
        return v;
    endfunction

    function automatic logic [127:0] s_transform(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = PI[x[8*i +: 8]];
        return y;
    endfunction

    typedef logic [NUM_ITERS-1:0][127:0] iter_const_t;

    // Entry n holds C[n+1] = L(Vec128(n+1)), folded to constants at elaboration.
    function automatic iter_const_t gen_iter_consts();
        iter_const_t c;
        for (int i = 0; i < NUM_ITERS; i++) c[i] = l_transform(128'(i + 1));
        return c;
    endfunction

    localparam iter_const_t ITER_C = gen_iter_consts();

endpackage

// File: rtl/kuznechik_lsx_round.sv
// rtl/kuznechik_lsx_round.sv - combinational y = L(S(a xor c))
module kuznechik_lsx_round
    import kuznechik_pkg::*;
(
    input  logic [127:0] a,
    input  logic [127:0] c,
    output logic [127:0] y
);

    assign y = l_transform(s_transform(a ^ c));

endmodule

// File: rtl/kuznechik_key_expand.sv
// rtl/kuznechik_key_expand.sv - Kuznechik round-key expansion; KUZNECHIK_KEY_REVERSE_EN emits K10..K1
module kuznechik_key_expand
    import kuznechik_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_last
);

    state_t       state_q, state_d;
    logic [4:0]   iter_q, iter_d;
    logic [3:0]   pos_q, pos_d;
    logic [127:0] a1_q, a1_d;
    logic [127:0] a0_q, a0_d;
    logic [127:0] slot_q [NUM_RKEYS];
    logic         load_key;
    logic         store_pair;
    logic [127:0] lsx_y;
    logic [3:0]   pair_base;
    logic [3:0]   sel;

    kuznechik_lsx_round u_lsx (
        .a (a1_q),
        .c (ITER_C[iter_q]),
        .y (lsx_y)
    );

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        pos_d      = pos_q;
        a1_d       = a1_q;
        a0_d       = a0_q;
        load_key   = 1'b0;
        store_pair = 1'b0;
        key_ready  = 1'b0;
        rk_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    load_key = 1'b1;
                    a1_d     = key[255:128];
                    a0_d     = key[127:0];
                    iter_d   = '0;
                    state_d  = EXPAND;
                end
            end
            EXPAND: begin
                a1_d       = lsx_y ^ a0_q;
                a0_d       = a1_q;
                store_pair = (iter_q[2:0] == 3'd7);
                if (iter_q == 5'd31) begin
                    state_d = EMIT;
                    pos_d   = '0;
                end else begin
                    iter_d = iter_q + 5'd1;
                end
            end
            EMIT: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    if (pos_q == 4'd9) begin
                        state_d = IDLE;
                        pos_d   = '0;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Each group of eight steps yields the next pair: slots 2,3 / 4,5 / 6,7 / 8,9.
    assign pair_base = {1'b0, iter_q[4:3], 1'b0} + 4'd2;

`ifdef KUZNECHIK_KEY_REVERSE_EN
    assign sel = 4'd9 - pos_q;
`else
    assign sel = pos_q;
`endif

    assign rk      = rk_valid ? slot_q[sel] : '0;
    assign rk_idx  = rk_valid ? (sel + 4'd1) : '0;
    assign rk_last = rk_valid && (pos_q == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            pos_q   <= pos_d;
        end
    end

    always_ff @(posedge clk) begin
        a1_q <= a1_d;
        a0_q <= a0_d;
        if (load_key && !rst) begin
            slot_q[0] <= key[255:128];
            slot_q[1] <= key[127:0];
        end
        if (store_pair && !rst) begin
            slot_q[pair_base]        <= a1_d;
            slot_q[pair_base + 4'd1] <= a0_d;
        end
    end

endmodule

// File: tb/tb_kuznechik_key_expand.sv
// tb/tb_kuznechik_key_expand.sv - scoreboard bench for kuznechik_key_expand
module tb_kuznechik_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_last;

    always #5 clk = ~clk;

    kuznechik_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last)
    );

`ifdef KUZNECHIK_KEY_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    localparam logic [255:0] TEST_KEY  = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [255:0] OTHER_KEY = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00102030405060708090a0b0c0d0e0f10;

    localparam logic [127:0] RK_REF [10] = '{
        128'h8899aabbccddeeff0011223344556677,
        128'hfedcba98765432100123456789abcdef,
        128'hdb31485315694343228d6aef8cc78c44,
        128'h3d4553d8e9cfec6815ebadc40a9ffd04,
        128'h57646468c44a5e28d3e59246f429f1ac,
        128'hbd079435165c6432b532e82834da581b,
        128'h51e640757e8745de705727265a0098b1,
        128'h5a7925017b9fdd3ed72a91a22286f984,
        128'hbb44e25378c73123a5f32f73cdb6e517,
        128'h72e9dd7416bcf45b755dbaa88e4a4043
    };

    typedef struct packed {
        logic [3:0]   idx;
        logic         last;
        logic [127:0] rk;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           accept_cyc = 0;
    bit           lat_armed = 1'b0;
    bit           kr_check = 1'b0;
    bit           hold = 1'b0;
    logic [127:0] hold_rk;
    logic [3:0]   hold_idx;
    logic         hold_last;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold     = 1'b0;
            kr_check = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 128'(rk_valid), 128'(1));
                check("hold_rk", rk, hold_rk);
                check("hold_idx", 128'(rk_idx), 128'(hold_idx));
                check("hold_last", 128'(rk_last), 128'(hold_last));
            end
            hold = 1'b0;
            if (kr_check) begin
                check("key_ready_after_last", 128'(key_ready), 128'(1));
                kr_check = 1'b0;
            end
            if (rk_valid && lat_armed) begin
                check("latency", 128'(cyc - accept_cyc), 128'(32));
                lat_armed = 1'b0;
            end
            if (rk_valid && rk_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rk: got idx %0d rk %h, required none", rk_idx, rk);
                end else begin
                    e = sb.pop_front();
                    check("rk_idx", 128'(rk_idx), 128'(e.idx));
                    check("rk_last", 128'(rk_last), 128'(e.last));
                    check("rk", rk, e.rk);
                    if (e.last) kr_check = 1'b1;
                end
            end else if (rk_valid) begin
                hold      = 1'b1;
                hold_rk   = rk;
                hold_idx  = rk_idx;
                hold_last = rk_last;
            end
        end
    end

    task automatic push_set();
        int k;
        for (int p = 0; p < 10; p++) begin
            k = REV ? 9 - p : p;
            sb.push_back('{idx: 4'(k + 1), last: (p == 9), rk: RK_REF[k]});
        end
    endtask

    task automatic send_key(input logic [255:0] k, input bit expect_set);
        int n = 0;
        while (!key_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!key_ready) begin
            total++;
            bad++;
            $display("FAIL key_ready_timeout: got 0, required 1");
        end
        key_valid = 1'b1;
        key       = k;
        @(posedge clk); #1;
        key_valid  = 1'b0;
        accept_cyc = cyc;
        if (expect_set) begin
            push_set();
            lat_armed = 1'b1;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || rk_valid) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL set_incomplete: got %0d keys outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_key_ready"}, 128'(key_ready), 128'(1));
        check({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
        check({tag, "_rk_idx"}, 128'(rk_idx), 128'(0));
        check({tag, "_rk_last"}, 128'(rk_last), 128'(0));
        check({tag, "_rk"}, rk, 128'(0));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        key_valid = 1'b0;
        key       = '0;
        rk_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain expansion with a consumer that never stalls.
        rk_ready = 1'b1;
        send_key(TEST_KEY, 1'b1);
        check("expand_key_ready", 128'(key_ready), 128'(0));
        wait_done();

        // Stall the third key for five cycles.
        rk_ready = 1'b0;
        send_key(TEST_KEY, 1'b1);
        n = 0;
        while (!rk_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        rk_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rk_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rk_ready = 1'b1;
        wait_done();

        // A second key offered during expansion is ignored.
        send_key(TEST_KEY, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        key_valid = 1'b1;
        key       = OTHER_KEY;
        repeat (10) begin
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        key       = '0;
        wait_done();

        // Reset in the middle of expansion, then restart.
        send_key(OTHER_KEY, 1'b0);
        repeat (12) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle("mid_reset");
        rst = 1'b0;
        send_key(TEST_KEY, 1'b1);
        wait_done();

        // Back-to-back key sets.
        send_key(TEST_KEY, 1'b1);
        send_key(TEST_KEY, 1'b1);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
